// File: rtl/abp_pkg.sv
// abp_pkg: shared types and helpers for the alternating bit protocol blocks.
package abp_pkg;
   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, FAIL} abp_tx_state_t;
   localparam int ABP_RETRY_W = 4;
   function automatic logic abp_toggle(input logic b);
      return ~b;
   endfunction
endpackage

// File: rtl/abp_ack_timer.sv
// abp_ack_timer: loadable saturating down-counter that flags expiry at zero.
module abp_ack_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT_CYCLES);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else if (load_i) cnt_q <= W'(TIMEOUT_CYCLES - 1);
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   end
   assign expired_o = cnt_q == '0;
endmodule

// File: rtl/abp_sender_ctrl.sv
// abp_sender_ctrl: alternating bit protocol sender; holds each beat until acked,
// retransmits on timeout and raises a sticky link error after MAX_RETRIES.
module abp_sender_ctrl
   import abp_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MAX_RETRIES    = 3
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   input  logic                   m_axis_tready,
   input  logic                   s_ack_tvalid,
   input  logic                   s_ack_tdata,
   output logic                   s_ack_tready,
   input  logic                   clear_err,
   output logic                   seq_bit,
   output logic [ABP_RETRY_W-1:0] retry_count,
   output logic                   link_err
);
   abp_tx_state_t         state_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q, user_q, seq_q, err_q;
   logic [ABP_RETRY_W-1:0] retry_q;
   logic                  load, expired, ack_match;

   assign load      = state_q == SEND && m_axis_tready;
   assign ack_match = s_ack_tvalid && s_ack_tdata == seq_q;

   abp_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i     (aclk),
      .rst_i     (areset),
      .load_i    (load),
      .expired_o (expired)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         data_q  <= '0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
         seq_q   <= 1'b0;
         err_q   <= 1'b0;
         retry_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (s_axis_tvalid) begin
               data_q  <= s_axis_tdata;
               last_q  <= s_axis_tlast;
               user_q  <= seq_q;
               state_q <= SEND;
            end
            SEND: if (m_axis_tready) state_q <= WAIT_ACK;
            WAIT_ACK: if (ack_match) begin
               seq_q   <= abp_toggle(seq_q);
               retry_q <= '0;
               state_q <= IDLE;
            end else if (expired) begin
               // retry budget exhausted: park in FAIL until software clears it
               if (retry_q == ABP_RETRY_W'(MAX_RETRIES)) begin
                  err_q   <= 1'b1;
                  state_q <= FAIL;
               end else begin
                  retry_q <= retry_q + 1'b1;
                  state_q <= SEND;
               end
            end
            FAIL: if (clear_err) begin
               err_q   <= 1'b0;
               retry_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_axis_tready = state_q == IDLE;
   assign m_axis_tvalid = state_q == SEND;
   assign m_axis_tdata  = data_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tuser  = user_q;
   assign s_ack_tready  = 1'b1;
   assign seq_bit       = seq_q;
   assign retry_count   = retry_q;
   assign link_err      = err_q;
endmodule

// File: doc/abp_sender_ctrl.md
Name: abp_sender_ctrl

Overview:
Sender-side sequencer for the alternating bit protocol and the counterpart of the ABP receiver.
- Accepts one payload beat at a time from upstream AXI Stream.
- Tags the beat with the current sequence bit and transmits it downstream.
- Holds the beat until a matching ack arrives, retransmitting on timeout.
- Declares a sticky link failure after MAX_RETRIES consecutive retransmissions.

Parameters:
DATA_WIDTH, 8, payload width in bits of the AXI Stream interfaces.
TIMEOUT_CYCLES, 64, cycles waited for an ack after a send handshake (legal range 2..65535).
MAX_RETRIES, 3, retransmissions allowed before failure (legal range 0..15).

Ports:
aclk  in  1  clock, all logic rising-edge.
areset  in  1  synchronous, active-high reset.
s_axis_tvalid  in  1  upstream payload valid.
s_axis_tdata  in  DATA_WIDTH  upstream payload.
s_axis_tlast  in  1  upstream end-of-frame marker.
s_axis_tready  out  1  high only in IDLE.
m_axis_tvalid  out  1  high only in SEND.
m_axis_tdata  out  DATA_WIDTH  held payload.
m_axis_tlast  out  1  held tlast.
m_axis_tuser  out  1  sequence bit of the held payload.
m_axis_tready  in  1  downstream ready.
s_ack_tvalid  in  1  ack valid.
s_ack_tdata  in  1  acknowledged sequence bit.
s_ack_tready  out  1  constant 1; acks are always drained.
clear_err  in  1  single-cycle pulse; exits FAIL.
seq_bit  out  1  current sequence bit.
retry_count  out  4  retransmissions of the current beat.
link_err  out  1  sticky; high in FAIL.

Behaviour:
- Reset values: state IDLE, seq_bit 0, retry_count 0, link_err 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, timer 0.
- Reset mid-operation aborts any frame; the held data is lost.
- IDLE: s_axis_tready=1. On an s_axis handshake:
  - capture tdata and tlast into the holding register;
  - set tuser to seq_bit;
  - move to SEND. m_axis_tvalid rises on the next cycle (1-cycle latency).
- SEND: m_axis_tvalid=1. Data, last and user are stable until the handshake. On m_axis_tready:
  - load timer with TIMEOUT_CYCLES-1;
  - move to WAIT_ACK.
- WAIT_ACK: timer decrements by 1 per cycle, saturating at 0.
  - Matching ack (s_ack_tvalid && s_ack_tdata==seq_bit): seq_bit toggles, retry_count clears, go to IDLE.
  - Non-matching ack: stale duplicate; ignored with no state change.
  - Timeout (timer==0, no matching ack this cycle), retry_count < MAX_RETRIES: retry_count increments, go to SEND. The holding register is unchanged, including tuser.
  - Timeout with retry_count == MAX_RETRIES: go to FAIL and set link_err.
  - Matching ack and timeout in the same cycle: the ack wins.
- Timing: if the send handshake is at cycle T, an ack is accepted through cycle T+TIMEOUT_CYCLES. Retransmit m_axis_tvalid rises at T+TIMEOUT_CYCLES+1.
- FAIL: s_axis_tready=0, m_axis_tvalid=0, acks drained and ignored. On clear_err:
  - link_err clears, retry_count clears;
  - the held beat is discarded; seq_bit is unchanged;
  - go to IDLE. clear_err outside FAIL has no effect.
- Acks in IDLE or SEND are drained and ignored. A matching ack during a retransmit SEND does not complete the beat; the beat completes only via an ack in WAIT_ACK.
- Timer width: $clog2(TIMEOUT_CYCLES). Width of retry_count is fixed at 4.

Decomposition:
- Shared package abp_pkg:
  - state enum abp_tx_state_t {IDLE, SEND, WAIT_ACK, FAIL};
  - localparam ABP_RETRY_W = 4;
  - a reusable seq-bit toggle helper function.
- Natural sub-module abp_ack_timer: a loadable down-counter with load and expired outputs, parameterised by TIMEOUT_CYCLES. It is reusable by a future receiver-side ack-pacing block.
- FSM and holding register stay in the top.

Test Plan:
1. Reset, then send 0xA5 with tlast=1; m_axis_tready=1; ack bit 0 three cycles later. Required: m_axis shows 0xA5/tuser 0/tlast 1 one cycle after accept; seq_bit becomes 1; s_axis_tready is high the cycle after the ack.
2. Send 0x11 then 0x22, each correctly acked. Required: tuser is 0 then 1; seq_bit returns to 0; retry_count stays 0.
3. Send 0x3C with no ack (TIMEOUT_CYCLES=64). Required: retransmit valid rises exactly 65 cycles after the first handshake with identical data/tuser; retry_count=1; an ack on the retransmit completes the beat.
4. Send with no acks and MAX_RETRIES=3. Required: 4 total transmissions; link_err rises after the 4th timeout; s_axis_tready stays 0. A clear_err pulse returns to IDLE with link_err=0, retry_count=0, seq_bit unchanged.
5. Wrong-bit ack (bit 1 while seq=0) in WAIT_ACK. Required: ignored, timer keeps running, timeout retransmit still occurs. Matching ack on the exact expiry cycle: completes the beat with no retransmit.
6. Assert areset during WAIT_ACK with retry_count=2. Required: the next cycle shows all outputs at reset values and seq_bit=0.
